// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for an NSTAGES-deep in-order pipeline.
// Produces per-pipeline-register enable/flush vectors and the PC enable,
// handling data-memory wait, load-use bubbles, branch redirect, fetch
// misses and a halt-drain sequence. Also keeps a saturating stall counter.
//
// Handshake note: there is no valid/ready pair here. ihit and dhit are
// level "complete this cycle" indications sampled every cycle; the unit
// answers combinationally in the same cycle through pc_en/pr_en/pr_flush.
module hazard_ctrl_unit #(
  parameter int NSTAGES   = 5,
  parameter int BR_STAGE  = 2,
  parameter int LU_STALLS = 1,
  parameter int REGW      = 5,
  parameter int CNTW      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dren,
  input  logic              mem_dwen,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic              ex_memread,
  input  logic [REGW-1:0]   ex_rd,
  input  logic              redirect,
  input  logic              id_halt,
  output logic              pc_en,
  output logic [NSTAGES-2:0] pr_en,
  output logic [NSTAGES-2:0] pr_flush,
  output logic              halt_out,
  output logic [CNTW-1:0]   stall_count
);

  localparam int NPR = NSTAGES - 1;
  localparam int CW  = $clog2(NSTAGES) + 1;

  // Registers younger than the resolve stage hold wrong-path instructions.
  localparam logic [NPR-1:0] BR_FLUSH = NPR'((1 << BR_STAGE) - 1);
  // Load-use: IF/ID holds, a bubble goes into ID/EX.
  localparam logic [NPR-1:0] LU_EN    = {{(NPR-1){1'b1}}, 1'b0};
  localparam logic [NPR-1:0] LU_FLUSH = NPR'(2);
  localparam logic [NPR-1:0] IF_FLUSH = NPR'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   lu_cnt, lu_cnt_n;
  logic [CW-1:0]   drain_cnt, drain_cnt_n;
  logic            stall_inc;
  logic            dmem_wait;
  logic            lu_hazard;

  assign dmem_wait = (mem_dren | mem_dwen) & ~dhit;
  assign lu_hazard = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

  // State and bubble/drain counters; a memory wait simply holds everything.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      lu_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      lu_cnt    <= lu_cnt_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  // Priority-ordered output decode and next-state selection.
  always_comb begin
    state_n     = state;
    lu_cnt_n    = lu_cnt;
    drain_cnt_n = drain_cnt;
    pc_en       = 1'b1;
    pr_en       = '1;
    pr_flush    = '0;
    halt_out    = 1'b0;
    stall_inc   = 1'b0;
    case (state)
      HALTED: begin
        halt_out = 1'b1;
        pc_en    = 1'b0;
        pr_en    = '0;
      end
      DRAIN: begin
        pc_en = 1'b0;
        if (dmem_wait) begin
          pr_en = '0;
        end else begin
          // Redirect is ignored: the HALT is older than any resolving branch.
          pr_flush    = IF_FLUSH;
          drain_cnt_n = drain_cnt + CW'(1);
          if (drain_cnt == CW'(NSTAGES - 3)) state_n = HALTED;
        end
      end
      default: begin
        if (dmem_wait) begin
          pc_en = 1'b0;
          pr_en = '0;
        end else if (redirect) begin
          // A redirect squashes the stalled instruction, so any bubble run ends.
          pr_flush = BR_FLUSH;
          state_n  = RUN;
          lu_cnt_n = '0;
        end else if (lu_hazard || (state == LU_STALL)) begin
          pc_en    = 1'b0;
          pr_en    = LU_EN;
          pr_flush = LU_FLUSH;
          if (state == RUN) begin
            if (LU_STALLS > 1) begin
              state_n  = LU_STALL;
              lu_cnt_n = CW'(1);
            end
          end else if (lu_cnt == CW'(LU_STALLS - 1)) begin
            state_n  = RUN;
            lu_cnt_n = '0;
          end else begin
            lu_cnt_n = lu_cnt + CW'(1);
          end
        end else if (!ihit) begin
          pc_en    = 1'b0;
          pr_flush = IF_FLUSH;
        end else if (id_halt) begin
          pc_en       = 1'b0;
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end
        stall_inc = ~pc_en;
      end
    endcase
  end

  // Saturating count of PC-stalled cycles outside the halt sequence.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_count <= '0;
    end else if (stall_inc && (stall_count != '1)) begin
      stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances share one stimulus stream
// (LU_STALLS=1/CNTW=32 and LU_STALLS=2/CNTW=4). A driver issues inputs
// and pushes the reference model's expected outputs; a monitor pops and
// compares on the falling edge.
module tb_hazard_ctrl_unit;

  localparam int NST = 5;
  localparam int BR  = 2;

  typedef struct packed {
    logic        pc;
    logic [3:0]  en;
    logic [3:0]  fl;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  localparam int EW = $bits(pair_t);

  logic clk = 1'b0;
  logic nrst;
  logic ihit, dhit, mem_dren, mem_dwen, ex_memread, redirect, id_halt;
  logic [4:0] id_rs, id_rt, ex_rd;

  logic        pc_a, pc_b, halt_a, halt_b;
  logic [3:0]  en_a, en_b, fl_a, fl_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state, one slot per instance.
  int              lu_left[2];
  bit              draining[2];
  int              drain_left[2];
  bit              halted[2];
  longint unsigned cnt_m[2];
  int              lu_par[2]   = '{1, 2};
  longint unsigned cnt_max[2]  = '{64'hFFFF_FFFF, 64'd15};

  hazard_ctrl_unit #(.NSTAGES(NST), .BR_STAGE(BR), .LU_STALLS(1), .REGW(5), .CNTW(32)) dut_a (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
    .mem_dwen(mem_dwen), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .redirect(redirect), .id_halt(id_halt), .pc_en(pc_a),
    .pr_en(en_a), .pr_flush(fl_a), .halt_out(halt_a), .stall_count(cnt_a)
  );

  hazard_ctrl_unit #(.NSTAGES(NST), .BR_STAGE(BR), .LU_STALLS(2), .REGW(5), .CNTW(4)) dut_b (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
    .mem_dwen(mem_dwen), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .redirect(redirect), .id_halt(id_halt), .pc_en(pc_b),
    .pr_en(en_b), .pr_flush(fl_b), .halt_out(halt_b), .stall_count(cnt_b)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lu_left[i] = 0; draining[i] = 0; drain_left[i] = 0;
      halted[i] = 0; cnt_m[i] = 0;
    end
  endtask

  task automatic bump(input int i);
    if (cnt_m[i] < cnt_max[i]) cnt_m[i]++;
  endtask

  // Expected outputs for the current cycle, then advance to the next edge.
  task automatic model_step(input int i, output exp_t e);
    bit wait_m, haz;
    e.pc = 1'b1; e.en = 4'hF; e.fl = 4'h0; e.halt = 1'b0;
    e.cnt = cnt_m[i][31:0];
    wait_m = (mem_dren || mem_dwen) && !dhit;
    haz = ex_memread && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
    if (halted[i]) begin
      e.pc = 0; e.en = 4'h0; e.halt = 1;
    end else if (wait_m) begin
      e.pc = 0; e.en = 4'h0;
      if (!draining[i]) bump(i);
    end else if (draining[i]) begin
      e.pc = 0; e.fl = 4'h1;
      drain_left[i]--;
      if (drain_left[i] == 0) begin
        halted[i] = 1; draining[i] = 0;
      end
    end else if (redirect) begin
      e.fl = 4'((1 << BR) - 1);
      lu_left[i] = 0;
    end else if (haz || lu_left[i] > 0) begin
      e.pc = 0; e.en = 4'hE; e.fl = 4'h2;
      bump(i);
      if (lu_left[i] > 0) lu_left[i]--;
      else lu_left[i] = lu_par[i] - 1;
    end else if (!ihit) begin
      e.pc = 0; e.fl = 4'h1;
      bump(i);
    end else if (id_halt) begin
      e.pc = 0;
      bump(i);
      draining[i] = 1; drain_left[i] = NST - 2;
    end
  endtask

  // Driver: change inputs just after the rising edge and queue expectations.
  task automatic apply(input logic ih, dh, dr, dw, input logic [4:0] rs, rt,
                       input logic mr, input logic [4:0] rd, input logic rdr, hl);
    pair_t p;
    @(posedge clk);
    #1;
    nrst = 1; ihit = ih; dhit = dh; mem_dren = dr; mem_dwen = dw;
    id_rs = rs; id_rt = rt; ex_memread = mr; ex_rd = rd; redirect = rdr; id_halt = hl;
    model_step(0, p.a);
    model_step(1, p.b);
    exp_q.push_back(EW'(p));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst = 0; ihit = 1; dhit = 1; mem_dren = 0; mem_dwen = 0;
    id_rs = 0; id_rt = 0; ex_memread = 0; ex_rd = 0; redirect = 0; id_halt = 0;
    model_reset();
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared.
  always @(negedge clk) begin
    pair_t p;
    if (exp_q.size() > 0) begin
      p = pair_t'(exp_q.pop_front());
      cmp("a_pc_en", {31'b0, pc_a}, {31'b0, p.a.pc});
      cmp("a_pr_en", {28'b0, en_a}, {28'b0, p.a.en});
      cmp("a_pr_flush", {28'b0, fl_a}, {28'b0, p.a.fl});
      cmp("a_halt_out", {31'b0, halt_a}, {31'b0, p.a.halt});
      cmp("a_stall_count", cnt_a, p.a.cnt);
      cmp("b_pc_en", {31'b0, pc_b}, {31'b0, p.b.pc});
      cmp("b_pr_en", {28'b0, en_b}, {28'b0, p.b.en});
      cmp("b_pr_flush", {28'b0, fl_b}, {28'b0, p.b.fl});
      cmp("b_halt_out", {31'b0, halt_b}, {31'b0, p.b.halt});
      cmp("b_stall_count", {28'b0, cnt_b}, p.b.cnt);
    end
  end

  // Stimulus: directed scenarios, then a randomized run.
  initial begin
    do_reset();
    idle(10);
    // Load-use on rs, then with ex_rd=0 (no hazard), then via rt.
    apply(1, 1, 0, 0, 5, 3, 1, 5, 0, 0);
    idle(3);
    apply(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 2, 9, 1, 9, 0, 0);
    idle(3);
    // Load-use followed by a redirect on the second bubble cycle.
    apply(1, 1, 0, 0, 5, 0, 1, 5, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // Data-memory wait over a load-use, then dhit releases it.
    for (int k = 0; k < 3; k++) apply(1, 0, 1, 0, 7, 0, 1, 7, 0, 0);
    apply(1, 1, 1, 0, 7, 0, 1, 7, 0, 0);
    idle(3);
    // Write wait together with a redirect: the wait wins.
    apply(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    apply(1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Halt drain, redirect ignored while draining, then reset out of HALTED.
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(6);
    do_reset();
    idle(3);
    // Long fetch miss: the 4-bit counter saturates at 15.
    for (int k = 0; k < 20; k++) apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Reset in the middle of a load-use bubble run.
    apply(1, 1, 0, 0, 4, 0, 1, 4, 0, 0);
    do_reset();
    idle(3);
    // Randomized run.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 1) do_reset();
      else apply($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 35, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
    end
    @(posedge clk);
    @(posedge clk);
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
